quadrant_switch_sequencer: RTL and testbench

- Clocked, multi-channel successor to the combinational quadrant selector.
- For each of NUM_CH CDU angle channels, it decodes the read-counter angle into:
  - sine and cosine quadrant sign selects, and
  - a one-hot MSA switch selection (active-low, like the _Dn controls).
- Every selection change is applied break-before-make: all switches open for a programmable dead time, then the new selection closes, followed by a settle interval before the channel reports settled.
- Sits between the read counters and the analog quadrant selector/MSA switches.

---
 rtl/quadrant_switch_sequencer_if.sv | 25 ++
 rtl/quadrant_switch_sequencer.sv | 118 +++++++++++
 tb/tb_quadrant_switch_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrant_switch_sequencer_if.sv
// Per-channel angle/hold inputs and break-before-make switch outputs of the
// quadrant switch sequencer. dbg_state carries each channel's FSM state.
interface quadrant_switch_sequencer_if #(
  parameter int NUM_CH  = 5,
  parameter int NSEG    = 4,
  parameter int ANGLE_W = 16
);
  logic [NUM_CH*ANGLE_W-1:0] angle;
  logic [NUM_CH-1:0]         hold;
  logic [NUM_CH*NSEG-1:0]    sw_n;
  logic [NUM_CH-1:0]         sin_neg_n;
  logic [NUM_CH-1:0]         cos_neg_n;
  logic [NUM_CH-1:0]         settled;
  logic [NUM_CH*2-1:0]       dbg_state;

  modport master (
    output angle, hold,
    input  sw_n, sin_neg_n, cos_neg_n, settled, dbg_state
  );

  modport slave (
    input  angle, hold,
    output sw_n, sin_neg_n, cos_neg_n, settled, dbg_state
  );
endinterface

// File: rtl/quadrant_switch_sequencer.sv
// Decodes each channel's angle into quadrant signs and a one-hot MSA switch,
// applying every selection change break-before-make with dead and settle time.
module quadrant_switch_sequencer #(
  parameter int NUM_CH        = 5,
  parameter int NSEG          = 4,
  parameter int ANGLE_W       = 16,
  parameter int DEAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  quadrant_switch_sequencer_if.slave bus
);
  localparam int SEG_BITS = $clog2(NSEG);
  localparam int MAX_CYC  = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int TW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] DEAD_LOAD   = TW'(DEAD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BREAK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2
  } state_t;

  typedef struct packed {
    logic                sin_neg;
    logic                cos_neg;
    logic [SEG_BITS-1:0] seg;
  } sel_t;

  function automatic logic [NSEG-1:0] close_mask(input logic [SEG_BITS-1:0] seg);
    close_mask = ~(NSEG'(1) << seg);
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]          q;
    logic [SEG_BITS-1:0] seg_d;
    sel_t                want_d;
    sel_t                want_q;
    sel_t                cur;
    state_t              state;
    logic [TW-1:0]       timer;
    logic [NSEG-1:0]     sw_q;
    logic                sin_q;
    logic                cos_q;
    logic                set_q;

    assign q      = bus.angle[g*ANGLE_W + ANGLE_W - 2 +: 2];
    assign seg_d  = bus.angle[g*ANGLE_W + ANGLE_W - 2 - SEG_BITS +: SEG_BITS];
    assign want_d = {q[1], q[1] ^ q[0], seg_d};

    // Outputs are registered alongside the state they belong to, so a
    // closure and its sign update land on the same edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        want_q <= '0;
        cur    <= '0;
        state  <= ST_BREAK;
        timer  <= DEAD_LOAD;
        sw_q   <= '1;
        sin_q  <= 1'b1;
        cos_q  <= 1'b1;
        set_q  <= 1'b0;
      end else begin
        if (!bus.hold[g]) want_q <= want_d;
        case (state)
          ST_BREAK: begin
            if (timer == '0) begin
              cur   <= want_q;
              timer <= SETTLE_LOAD;
              state <= ST_SETTLE;
              sw_q  <= close_mask(want_q.seg);
              sin_q <= ~want_q.sin_neg;
              cos_q <= ~want_q.cos_neg;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          ST_SETTLE: begin
            // A changed selection wins even on the cycle the settle time expires.
            if (want_q != cur) begin
              state <= ST_BREAK;
              timer <= DEAD_LOAD;
              sw_q  <= '1;
              set_q <= 1'b0;
            end else if (timer == '0) begin
              state <= ST_ON;
              set_q <= 1'b1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          ST_ON: begin
            if (want_q != cur) begin
              state <= ST_BREAK;
              timer <= DEAD_LOAD;
              sw_q  <= '1;
              set_q <= 1'b0;
            end
          end
          default: begin
            state <= ST_BREAK;
            timer <= DEAD_LOAD;
            sw_q  <= '1;
            set_q <= 1'b0;
          end
        endcase
      end
    end

    assign bus.sw_n[g*NSEG +: NSEG] = sw_q;
    assign bus.sin_neg_n[g]         = sin_q;
    assign bus.cos_neg_n[g]         = cos_q;
    assign bus.settled[g]           = set_q;
    assign bus.dbg_state[g*2 +: 2]  = state;
  end
endmodule

// File: tb/tb_quadrant_switch_sequencer.sv
// Directed scenarios plus randomized angle/hold/reset traffic, checked every
// cycle against an event-counting model of the break-before-make sequencing.
module tb_quadrant_switch_sequencer;
  localparam int NUM_CH   = 2;
  localparam int NSEG     = 4;
  localparam int ANGLE_W  = 16;
  localparam int DEAD     = 2;
  localparam int SETTLE   = 3;
  localparam int SEG_BITS = 2;
  localparam int SWW      = NUM_CH * NSEG;
  localparam int W        = SWW + 3 * NUM_CH;

  bit   clk;
  logic rst_n;

  quadrant_switch_sequencer_if #(.NUM_CH(NUM_CH), .NSEG(NSEG), .ANGLE_W(ANGLE_W)) bus ();

  quadrant_switch_sequencer #(
    .NUM_CH(NUM_CH), .NSEG(NSEG), .ANGLE_W(ANGLE_W),
    .DEAD_CYCLES(DEAD), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check / counters ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_angle(input int c, input logic [ANGLE_W-1:0] v);
    bus.angle[c*ANGLE_W +: ANGLE_W] = v;
  endtask

  // ---------------- reference model ----------------
  // Each channel is either open (counting edges since it opened) or closed on
  // an applied selection (counting edges since closure, saturating).
  int unsigned m_want [NUM_CH];
  int unsigned m_cur  [NUM_CH];
  bit          m_closed [NUM_CH];
  int          m_open [NUM_CH];
  int          m_age  [NUM_CH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_vec;

  function automatic int unsigned tuple_of(input int unsigned a);
    int unsigned q, sn, cn, seg;
    q   = a / (1 << (ANGLE_W - 2));
    sn  = (q >= 2) ? 1 : 0;
    cn  = (q == 1 || q == 2) ? 1 : 0;
    seg = (a / (1 << (ANGLE_W - 2 - SEG_BITS))) % NSEG;
    return (sn * 2 + cn) * NSEG + seg;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        m_want[c] = 0; m_cur[c] = 0; m_closed[c] = 0; m_open[c] = 0; m_age[c] = 0;
      end else begin
        if (m_closed[c]) begin
          if (m_want[c] != m_cur[c]) begin
            m_closed[c] = 0;
            m_open[c]   = 0;
          end else if (m_age[c] < SETTLE) begin
            m_age[c]++;
          end
        end else begin
          if (m_open[c] == DEAD - 1) begin
            m_closed[c] = 1;
            m_cur[c]    = m_want[c];
            m_age[c]    = 0;
          end else begin
            m_open[c]++;
          end
        end
        if (!bus.hold[c]) m_want[c] = tuple_of(32'(bus.angle[c*ANGLE_W +: ANGLE_W]));
      end
      for (int s = 0; s < NSEG; s++)
        e_vec[c*NSEG + s] = !(m_closed[c] && (m_cur[c] % NSEG) == s);
      e_vec[SWW + c]            = (m_cur[c] / (2 * NSEG)) == 0;
      e_vec[SWW + NUM_CH + c]   = ((m_cur[c] / NSEG) % 2) == 0;
      e_vec[SWW + 2*NUM_CH + c] = m_closed[c] && (m_age[c] >= SETTLE);
    end
    exp_q.push_back(e_vec);
  end

  // ---------------- scoreboard + invariants ----------------
  logic [W-1:0]    obs;
  logic [NSEG-1:0] prev_sw [NUM_CH];
  logic [1:0]      prev_sg [NUM_CH];
  bit              prev_ok = 0;

  always @(negedge clk) begin
    obs = {bus.settled, bus.cos_neg_n, bus.sin_neg_n, bus.sw_n};
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) check_eq("sb_outputs", obs, exp_q.pop_front());
    for (int c = 0; c < NUM_CH; c++) begin
      logic [NSEG-1:0] sw;
      logic [1:0]      sg;
      int              zeros;
      sw = bus.sw_n[c*NSEG +: NSEG];
      sg = {bus.sin_neg_n[c], bus.cos_neg_n[c]};
      zeros = 0;
      for (int s = 0; s < NSEG; s++) if (!sw[s]) zeros++;
      check_eq("onehot", (zeros <= 1), 1);
      if (prev_ok && sw != '1 && prev_sw[c] != '1) begin
        check_eq("sw_stable", sw, prev_sw[c]);
        check_eq("sign_stable", sg, prev_sg[c]);
      end
      prev_sw[c] = sw;
      prev_sg[c] = sg;
    end
    prev_ok = 1;
  end

  // ---------------- stimulus ----------------
  logic [15:0] sweep_ang [3];
  logic [1:0]  sweep_sg  [3];

  initial begin
    sweep_ang = '{16'h4000, 16'h8000, 16'hC000};
    sweep_sg  = '{2'b10, 2'b00, 2'b01};
    rst_n = 1'b0;
    bus.angle = '0;
    bus.hold  = '0;
    step(3);

    // reset release
    rst_n = 1'b1;
    check_eq("rel_c1_sw", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("rel_c2_sw", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("rel_c3_sw", bus.sw_n[3:0], 4'hE);
    check_eq("rel_c3_sin", bus.sin_neg_n[0], 1'b1);
    check_eq("rel_c3_cos", bus.cos_neg_n[0], 1'b1);
    step(2); check_eq("rel_c5_set", bus.settled[0], 1'b0);
    step(1); check_eq("rel_c6_set", bus.settled[0], 1'b1);

    // single change 0x0000 -> 0x1000
    set_angle(0, 16'h1000);
    step(1); check_eq("chg_a0_sw", bus.sw_n[3:0], 4'hE);
    step(1); check_eq("chg_a1_sw", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("chg_a2_sw", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("chg_a3_sw", bus.sw_n[3:0], 4'hD);
    check_eq("chg_a3_set", bus.settled[0], 1'b0);
    step(2); check_eq("chg_a5_set", bus.settled[0], 1'b0);
    step(1); check_eq("chg_a6_set", bus.settled[0], 1'b1);
    check_eq("chg_ch1_sw", bus.sw_n[7:4], 4'hE);
    check_eq("chg_ch1_set", bus.settled[1], 1'b1);

    // quadrant sweep
    for (int i = 0; i < 3; i++) begin
      set_angle(0, sweep_ang[i]);
      step(10);
      check_eq("sweep_sign", {bus.sin_neg_n[0], bus.cos_neg_n[0]}, sweep_sg[i]);
      check_eq("sweep_sw", bus.sw_n[3:0], 4'hE);
    end

    // change one cycle after closure
    set_angle(0, 16'h1000);
    step(4); check_eq("mid_close_sw", bus.sw_n[3:0], 4'hD);
    set_angle(0, 16'h2000);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_eq("mid_no_set", bus.settled[0], 1'b0);
      if (k == 2 || k == 3) check_eq("mid_open", bus.sw_n[3:0], 4'hF);
      if (k == 4) check_eq("mid_reclose", bus.sw_n[3:0], 4'hB);
    end
    step(1); check_eq("mid_set", bus.settled[0], 1'b1);

    // hold freezes the wanted selection
    bus.hold[0] = 1'b1;
    set_angle(0, 16'h3000);
    for (int k = 0; k < 6; k++) begin
      step(1);
      check_eq("hold_sw", bus.sw_n[3:0], 4'hB);
      check_eq("hold_set", bus.settled[0], 1'b1);
    end
    bus.hold[0] = 1'b0;
    step(1); check_eq("unhold_b0", bus.sw_n[3:0], 4'hB);
    step(2); check_eq("unhold_b2", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("unhold_b3", bus.sw_n[3:0], 4'h7);
    step(3); check_eq("unhold_set", bus.settled[0], 1'b1);

    // reset while ON
    rst_n = 1'b0;
    step(1);
    check_eq("rst_sw", bus.sw_n, 8'hFF);
    check_eq("rst_set", bus.settled, 2'b00);
    check_eq("rst_sin", bus.sin_neg_n, 2'b11);
    check_eq("rst_cos", bus.cos_neg_n, 2'b11);
    rst_n = 1'b1;
    step(1); check_eq("rerel_c2_sw", bus.sw_n[3:0], 4'hF);
    step(1); check_eq("rerel_c3_sw", bus.sw_n[3:0], 4'h7);
    step(3); check_eq("rerel_set", bus.settled[0], 1'b1);

    // wrap 0xFFFF -> 0x0000
    set_angle(0, 16'hFFFF);
    step(10);
    check_eq("wrap_hi_sign", {bus.sin_neg_n[0], bus.cos_neg_n[0]}, 2'b01);
    check_eq("wrap_hi_sw", bus.sw_n[3:0], 4'h7);
    set_angle(0, 16'h0000);
    step(2); check_eq("wrap_open", bus.sw_n[3:0], 4'hF);
    step(8);
    check_eq("wrap_lo_sign", {bus.sin_neg_n[0], bus.cos_neg_n[0]}, 2'b11);
    check_eq("wrap_lo_sw", bus.sw_n[3:0], 4'hE);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       set_angle(c, 16'hFFFF);
            1:       set_angle(c, 16'h0000);
            default: set_angle(c, 16'($urandom_range(0, 65535)));
          endcase
        end
        bus.hold[c] = ($urandom_range(0, 3) == 0);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step(1);
    end
    rst_n = 1'b1;
    bus.hold = '0;
    step(12);

    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
